// File: rtl/ram_access_arbiter.sv
// Shares one RAM port between fetch and load/store requesters; checks alignment, extends loads, aborts hung accesses.
// Latency: req sampled at edge N -> gnt/ram_en during N+1 -> done one cycle after MFC (misaligned/illegal: done during N+1).
// Backpressure: requests wait while busy; optional round-robin tie-break via `define ARB_ROUND_ROBIN_EN.
module ram_access_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              RESET,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic              if_err,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_signed,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic              d_err,
    output logic [31:0]       d_rdata,
    output logic              ram_en,
    output logic [5:0]        ram_opcode,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic              ram_mfc
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_MFC, DONE} state_t;

    state_t            state, state_nxt;
    logic              own_d;
    logic              op_we;
    logic              op_sgn;
    logic [1:0]        op_size;
    logic [ADDR_W-1:0] op_addr;
    logic [31:0]       op_wdata;
    logic              err_q;
    logic [7:0]        cnt;
    logic              pick_d;
    logic              pick_any;
    logic              pick_bad;
    logic              timeout_hit;
    logic [31:0]       ext_rdata;

`ifdef ARB_ROUND_ROBIN_EN
    logic              last_d;
    // On a tie, the requester that did not win last time goes first.
    assign pick_d = d_req && (!if_req || !last_d);
`else
    assign pick_d = d_req;
`endif

    assign pick_any    = d_req || if_req;
    assign pick_bad    = pick_d ? ((d_size == 2'b11) ||
                                   (d_size == 2'b01 && d_addr[0]) ||
                                   (d_size == 2'b10 && d_addr[1:0] != 2'b00))
                                : (if_addr[1:0] != 2'b00);
    assign timeout_hit = (cnt == 8'(TIMEOUT - 1));

    always_comb begin
        ext_rdata = ram_rdata;
        case (op_size)
            2'b00:   ext_rdata = {{24{op_sgn & ram_rdata[7]}}, ram_rdata[7:0]};
            2'b01:   ext_rdata = {{16{op_sgn & ram_rdata[15]}}, ram_rdata[15:0]};
            default: ext_rdata = ram_rdata;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (pick_any) state_nxt = pick_bad ? DONE : ISSUE;
            ISSUE:    state_nxt = ram_mfc ? DONE : WAIT_MFC;
            WAIT_MFC: if (ram_mfc || timeout_hit) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ram_en     = (state == ISSUE) || (state == WAIT_MFC);
        if_gnt     = (state == ISSUE) && !own_d;
        d_gnt      = (state == ISSUE) && own_d;
        if_done    = (state == DONE) && !own_d;
        d_done     = (state == DONE) && own_d;
        if_err     = if_done && err_q;
        d_err      = d_done && err_q;
        ram_opcode = ram_en ? {2'b00, op_sgn, op_we, op_size} : 6'd0;
        ram_addr   = ram_en ? op_addr : '0;
        ram_wdata  = (ram_en && op_we) ? op_wdata : 32'd0;
    end

    always_ff @(posedge Clk) begin
        if (RESET) begin
            own_d    <= 1'b0;
            op_we    <= 1'b0;
            op_sgn   <= 1'b0;
            op_size  <= 2'b00;
            op_addr  <= '0;
            op_wdata <= 32'd0;
            err_q    <= 1'b0;
            cnt      <= 8'd0;
            if_rdata <= 32'd0;
            d_rdata  <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        own_d <= pick_d;
                        err_q <= pick_bad;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d <= pick_d;
`endif
                        if (pick_d) begin
                            op_we    <= d_we;
                            op_sgn   <= d_signed;
                            op_size  <= d_size;
                            op_addr  <= d_addr;
                            op_wdata <= d_wdata;
                        end else begin
                            // A fetch looks like an unsigned word load on the RAM opcode.
                            op_we    <= 1'b0;
                            op_sgn   <= 1'b0;
                            op_size  <= 2'b10;
                            op_addr  <= if_addr;
                            op_wdata <= 32'd0;
                        end
                    end
                end
                ISSUE, WAIT_MFC: begin
                    if (ram_mfc) begin
                        if (!own_d)     if_rdata <= ram_rdata;
                        else if (!op_we) d_rdata <= ext_rdata;
                    end else if (state == ISSUE) begin
                        cnt <= 8'd0;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Shares the single datapath RAM port between the control unit's instruction-fetch requester and its load/store requester.
- Sequences each access: arbitrate, drive RAM_OpCode/address/enable, wait for MFC, then return data with a done pulse.
- Checks alignment, sign/zero-extends loads, and aborts hung accesses with a timeout.
- Sits between ControlUnit2 and the ram instance inside DataPath2.

Parameters:
- ADDR_W, 9, byte-address width of the RAM (512 bytes).
- TIMEOUT, 15, maximum cycles in WAIT_MFC before an access is aborted (1..255).

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  ADDR_W  fetch byte address (word access).
- if_gnt  out  1  one-cycle pulse: fetch access issued.
- if_done  out  1  one-cycle pulse: fetch complete.
- if_err  out  1  valid with if_done: misaligned or timeout.
- if_rdata  out  32  fetched word; held until the next if_done.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- d_signed  in  1  sign-extend load (ignored for stores).
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data, right-justified.
- d_gnt  out  1  one-cycle pulse: data access issued.
- d_done  out  1  one-cycle pulse: data access complete.
- d_err  out  1  valid with d_done: misaligned, illegal size, or timeout.
- d_rdata  out  32  extended load data; held until the next d_done.
- ram_en  out  1  RAM enable.
- ram_opcode  out  6  {2'b00, signed, we, size[1:0]}; fetch = 6'b000010.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_wdata  out  32  d_wdata passed through during a store.
- ram_rdata  in  32  RAM read data, right-justified.
- ram_mfc  in  1  memory function complete.

Behaviour:
- Reset values:
  - State IDLE.
  - All gnt/done/err outputs 0.
  - ram_en 0, ram_opcode 0, ram_addr 0, ram_wdata 0.
  - if_rdata and d_rdata 0.
  - Timeout counter 0.
- FSM states: IDLE, ISSUE, WAIT_MFC, DONE.
- IDLE:
  - Sample the requests each cycle.
  - Arbitration is fixed priority: data over fetch.
  - Winner latched as the owner; go to ISSUE.
  - Misaligned or illegal owner requests skip the RAM and go directly to DONE with err=1:
    - halfword with addr[0]=1;
    - word or fetch with addr[1:0]≠0;
    - d_size=11.
- ISSUE (one cycle):
  - Pulse the owner's gnt.
  - Assert ram_en; drive ram_opcode, ram_addr and ram_wdata (stores only; otherwise 0) from the owner's inputs.
  - Clear the counter; go to WAIT_MFC.
  - If ram_mfc is already 1 in this cycle, go straight to DONE and capture data.
- WAIT_MFC:
  - Hold ram_en and operands.
  - On ram_mfc=1: capture ram_rdata, drop ram_en next edge, go to DONE.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT: drop ram_en, go to DONE with err=1; the rdata register is unchanged.
- DONE (one cycle):
  - Pulse the owner's done (and err if set).
  - Load rdata:
    - byte: ram_rdata[7:0] extended to 32;
    - half: ram_rdata[15:0] extended to 32;
    - word/fetch: unchanged.
    - Extension is sign if d_signed, else zero.
  - Stores do not update d_rdata.
  - Return to IDLE.
- Latency: req sampled at edge N → gnt and ram_en at N+1 → with MFC at N+1, done at N+2. Minimum 3 cycles request-to-next-grant.
- A requester must drop its req in the cycle after done, or it is re-arbitrated as a new access.
- Requests arriving during a non-IDLE state wait; they are not lost.
- Simultaneous if_req and d_req in IDLE: data wins; fetch is granted on the next IDLE.
- ram_mfc outside WAIT_MFC/ISSUE is ignored.
- RESET mid-access: next edge returns to reset values; no done pulse; the owner is cleared.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: arbitration alternates. When both request, the requester not granted last time wins; the last-winner flag resets to "data" so fetch wins the first tie.
- Undefined: fixed data-over-fetch priority as above.

Test Plan:
- Fetch word, if_addr=0x010, RAM returns 0x10800000 with MFC two cycles after ram_en → if_gnt at N+1, ram_opcode=000010, if_done at N+4, if_rdata=0x10800000, if_err=0.
- Signed byte load, d_addr=0x003, ram_rdata=0x000000F3 → d_rdata=0xFFFFFFF3. Repeat with d_signed=0 → 0x000000F3.
- Halfword store at d_addr=0x005 → no ram_en, d_done with d_err=1 two cycles after request, ram_wdata stays 0.
- if_req and d_req asserted in the same cycle:
  - fixed mode: d_gnt first, then if_gnt;
  - with ARB_ROUND_ROBIN_EN: if_gnt first, on the next tie d_gnt.
- ram_mfc held 0 with TIMEOUT=15 → ram_en high exactly 16 cycles, then d_done with d_err=1, and d_rdata keeps its prior value.
- RESET pulsed during WAIT_MFC → next cycle ram_en=0, no done pulse, state IDLE; a new d_req is granted normally.
